// File: rtl/sprite_blitter.sv
// Sprite frame copier: walks a W x H source frame, applies colour-key and clipping,
// and issues one registered framebuffer write per visible pixel.
module sprite_blitter #(
   parameter int unsigned W      = 32,
   parameter int unsigned H      = 32,
   parameter int unsigned FB_W   = 160,
   parameter int unsigned FB_H   = 120,
   parameter logic [15:0] KEY    = 16'hF81F,
   parameter bit          KEY_EN = 1'b1
) (
   input  logic        clk_10,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  frame_sel,
   input  logic [7:0]  dst_x,
   input  logic [7:0]  dst_y,
   output logic [3:0]  step,
   output logic [7:0]  ram_addr_x,
   output logic [7:0]  ram_addr_y,
   input  logic [15:0] ram_data,
   output logic        wr_en,
   output logic [7:0]  wr_x,
   output logic [7:0]  wr_y,
   output logic [15:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic [16:0] wr_count
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 9;
   localparam int unsigned CW = 17;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   logic [AW-1:0]  org_x;
   logic [AW-1:0]  org_y;

   logic [DW-1:0]  dx_c;
   logic [DW-1:0]  dy_c;
   logic           keyed_c;
   logic           visible_c;
   logic           last_x_c;
   logic           last_y_c;

   // Destination of the pixel being read this cycle; 9 bits so an offset past 255 clips instead of wrapping.
   assign dx_c      = DW'(org_x) + DW'(ram_addr_x);
   assign dy_c      = DW'(org_y) + DW'(ram_addr_y);
   assign keyed_c   = KEY_EN && (ram_data == KEY);
   assign visible_c = !keyed_c && (dx_c < DW'(FB_W)) && (dy_c < DW'(FB_H));
   assign last_x_c  = (ram_addr_x == AW'(W - 1));
   assign last_y_c  = (ram_addr_y == AW'(H - 1));

   // The read address registers double as the column/row scan counters.
   always_ff @(posedge clk_10) begin
      if (rst) begin
         state      <= IDLE;
         step       <= '0;
         org_x      <= '0;
         org_y      <= '0;
         ram_addr_x <= '0;
         ram_addr_y <= '0;
         wr_en      <= 1'b0;
         wr_x       <= '0;
         wr_y       <= '0;
         wr_data    <= '0;
         wr_count   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  step       <= frame_sel;
                  org_x      <= dst_x;
                  org_y      <= dst_y;
                  ram_addr_x <= '0;
                  ram_addr_y <= '0;
                  wr_count   <= '0;
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               wr_en   <= visible_c;
               wr_x    <= dx_c[AW-1:0];
               wr_y    <= dy_c[AW-1:0];
               wr_data <= ram_data;
               if (visible_c) begin
                  wr_count <= wr_count + CW'(1);
               end
               if (last_x_c) begin
                  if (last_y_c) begin
                     state <= FLUSH;
                  end else begin
                     ram_addr_x <= '0;
                     ram_addr_y <= ram_addr_y + AW'(1);
                  end
               end else begin
                  ram_addr_x <= ram_addr_x + AW'(1);
               end
            end
            FLUSH: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized bench for sprite_blitter: a per-copy expected write list is derived from
// the frame contents, offset, key and framebuffer bounds, then checked cycle by cycle.
module tb_sprite_blitter;

   localparam logic [15:0] KEY = 16'hF81F;

   logic             clk_10 = 1'b0;
   logic             rst;
   logic [2:0]       start_v;
   logic [3:0]       frame_sel;
   logic [7:0]       dst_x;
   logic [7:0]       dst_y;

   logic [2:0][3:0]  step;
   logic [2:0][7:0]  ax;
   logic [2:0][7:0]  ay;
   logic [2:0][15:0] rd;
   logic [2:0]       we;
   logic [2:0][7:0]  wx;
   logic [2:0][7:0]  wy;
   logic [2:0][15:0] wd;
   logic [2:0]       bz;
   logic [2:0]       dn;
   logic [2:0][16:0] wc;

   logic [15:0]      salt;
   logic [7:0]       keybits [16];
   logic [1:0]       sel_cur;

   int               vectors = 0;
   int               miscompares = 0;

   always #50 clk_10 = ~clk_10;

   // Source frames: a salted hash, with per-frame key pixels planted in the top-left 4x2 block.
   function automatic logic [15:0] src(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
      if (x < 8'd4 && y < 8'd2 && keybits[f][{y[0], x[1:0]}]) return KEY;
      return 16'(salt + 16'(f) * 16'd4099 + 16'(x) * 16'd257 + 16'(y) * 16'd31);
   endfunction

   always_comb rd[0] = src(step[0], ax[0], ay[0]);
   always_comb rd[1] = src(step[1], ax[1], ay[1]);
   always_comb rd[2] = src(step[2], ax[2], ay[2]);

   sprite_blitter #(.W(4), .H(2)) u_small (
      .clk_10(clk_10), .rst(rst), .start(start_v[0]), .frame_sel(frame_sel),
      .dst_x(dst_x), .dst_y(dst_y), .step(step[0]), .ram_addr_x(ax[0]), .ram_addr_y(ay[0]),
      .ram_data(rd[0]), .wr_en(we[0]), .wr_x(wx[0]), .wr_y(wy[0]), .wr_data(wd[0]),
      .busy(bz[0]), .done(dn[0]), .wr_count(wc[0]));

   sprite_blitter #(.W(4), .H(2), .KEY_EN(1'b0)) u_nokey (
      .clk_10(clk_10), .rst(rst), .start(start_v[1]), .frame_sel(frame_sel),
      .dst_x(dst_x), .dst_y(dst_y), .step(step[1]), .ram_addr_x(ax[1]), .ram_addr_y(ay[1]),
      .ram_data(rd[1]), .wr_en(we[1]), .wr_x(wx[1]), .wr_y(wy[1]), .wr_data(wd[1]),
      .busy(bz[1]), .done(dn[1]), .wr_count(wc[1]));

   sprite_blitter u_big (
      .clk_10(clk_10), .rst(rst), .start(start_v[2]), .frame_sel(frame_sel),
      .dst_x(dst_x), .dst_y(dst_y), .step(step[2]), .ram_addr_x(ax[2]), .ram_addr_y(ay[2]),
      .ram_data(rd[2]), .wr_en(we[2]), .wr_x(wx[2]), .wr_y(wy[2]), .wr_data(wd[2]),
      .busy(bz[2]), .done(dn[2]), .wr_count(wc[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag, input int s);
      chk({tag, " step"}, 32'(step[s]), 0);
      chk({tag, " ram_addr_x"}, 32'(ax[s]), 0);
      chk({tag, " ram_addr_y"}, 32'(ay[s]), 0);
      chk({tag, " wr_en"}, 32'(we[s]), 0);
      chk({tag, " wr_x"}, 32'(wx[s]), 0);
      chk({tag, " wr_y"}, 32'(wy[s]), 0);
      chk({tag, " wr_data"}, 32'(wd[s]), 0);
      chk({tag, " busy"}, 32'(bz[s]), 0);
      chk({tag, " done"}, 32'(dn[s]), 0);
      chk({tag, " wr_count"}, 32'(wc[s]), 0);
   endtask

   // Called just after a falling edge. mode 0: plain copy, 1: extra start in cycle 5, 2: reset in cycle 4.
   task automatic run_copy(input int s, input logic [3:0] f, input logic [7:0] x0,
                           input logic [7:0] y0, input int mode);
      int          w, h, n, total, x, y, dx, dy;
      bit          keyen;
      logic [15:0] d;
      logic        pass_q [1024];
      logic [7:0]  ex_x [1024];
      logic [7:0]  ex_y [1024];
      logic [15:0] ex_d [1024];
      w     = (s == 2) ? 32 : 4;
      h     = (s == 2) ? 32 : 2;
      keyen = (s != 1);
      n     = w * h;
      total = 0;
      sel_cur = 2'(s);
      for (int i = 0; i < n; i++) begin
         x  = i % w;
         y  = i / w;
         d  = src(f, 8'(x), 8'(y));
         dx = int'(x0) + x;
         dy = int'(y0) + y;
         pass_q[i] = !(keyen && d == KEY) && dx < 160 && dy < 120;
         ex_x[i] = 8'(dx);
         ex_y[i] = 8'(dy);
         ex_d[i] = d;
         if (pass_q[i]) total++;
      end

      frame_sel  = f;
      dst_x      = x0;
      dst_y      = y0;
      start_v[s] = 1'b1;
      @(posedge clk_10);
      #1;
      start_v    = '0;
      frame_sel  = 4'($urandom);
      dst_x      = 8'($urandom);
      dst_y      = 8'($urandom);

      for (int c = 1; c <= n + 2; c++) begin
         @(negedge clk_10);
         chk($sformatf("busy@%0d", c), 32'(bz[s]), 32'(c <= n + 1));
         chk($sformatf("done@%0d", c), 32'(dn[s]), 32'(c == n + 2));
         if (c <= n) begin
            chk($sformatf("ram_addr_x@%0d", c), 32'(ax[s]), 32'((c - 1) % w));
            chk($sformatf("ram_addr_y@%0d", c), 32'(ay[s]), 32'((c - 1) / w));
         end
         if (c >= 2 && c <= n + 1 && pass_q[c - 2]) begin
            chk($sformatf("wr_en@%0d", c), 32'(we[s]), 1);
            chk($sformatf("wr_x@%0d", c), 32'(wx[s]), 32'(ex_x[c - 2]));
            chk($sformatf("wr_y@%0d", c), 32'(wy[s]), 32'(ex_y[c - 2]));
            chk($sformatf("wr_data@%0d", c), 32'(wd[s]), 32'(ex_d[c - 2]));
         end else begin
            chk($sformatf("wr_en@%0d", c), 32'(we[s]), 0);
         end
         if (c == 1 || c == n + 2) chk($sformatf("step@%0d", c), 32'(step[s]), 32'(f));
         if (c == n + 2) chk("wr_count@done", 32'(wc[s]), 32'(total));
         if (mode == 1 && c == 5) begin
            frame_sel  = f + 4'd1;
            start_v[s] = 1'b1;
            @(posedge clk_10);
            #1;
            start_v    = '0;
         end
         if (mode == 2 && c == 4) begin
            rst = 1'b1;
            @(posedge clk_10);
            #1;
            rst = 1'b0;
            @(negedge clk_10);
            chk_all_zero("after_rst", s);
            for (int k = 0; k < n + 4; k++) begin
               @(negedge clk_10);
               chk($sformatf("no_done_after_rst@%0d", k), 32'(dn[s]), 0);
               chk($sformatf("idle_after_rst@%0d", k), 32'({bz[s], we[s]}), 0);
            end
            return;
         end
      end
      @(negedge clk_10);
      chk("done_after", 32'(dn[s]), 0);
      chk("busy_after", 32'(bz[s]), 0);
      chk("wr_count_hold", 32'(wc[s]), 32'(total));
      chk("step_hold", 32'(step[s]), 32'(f));
   endtask

   initial begin
      salt      = 16'($urandom);
      for (int i = 0; i < 16; i++) keybits[i] = '0;
      sel_cur   = '0;
      rst       = 1'b1;
      start_v   = 3'b111;
      frame_sel = 4'd9;
      dst_x     = 8'd0;
      dst_y     = 8'd0;
      repeat (2) @(posedge clk_10);
      #1;
      start_v = '0;
      rst     = 1'b0;
      @(negedge clk_10);
      for (int s = 0; s < 3; s++) chk_all_zero($sformatf("reset[%0d]", s), s);

      // Plain copy, key pixel skipped (and not skipped without keying), clipped corner.
      run_copy(0, 4'd3, 8'd0, 8'd0, 0);
      keybits[5] = 8'h40;
      run_copy(0, 4'd5, 8'd0, 8'd0, 0);
      run_copy(1, 4'd5, 8'd0, 8'd0, 0);
      run_copy(0, 4'd7, 8'd158, 8'd119, 0);
      // Start while busy is ignored; back-to-back start right after done.
      run_copy(0, 4'd2, 8'd10, 8'd20, 1);
      run_copy(0, 4'd4, 8'd30, 8'd40, 0);
      // Reset mid-copy, then a full copy from the origin.
      run_copy(0, 4'd6, 8'd5, 8'd5, 2);
      run_copy(0, 4'd6, 8'd0, 8'd0, 0);
      // Full-size frame entirely off-screen.
      run_copy(2, 4'd15, 8'd200, 8'd0, 0);

      for (int r = 0; r < 16; r++) begin
         logic [3:0] f;
         logic [7:0] x0, y0;
         f  = 4'($urandom);
         keybits[f] = 8'($urandom);
         salt = 16'($urandom);
         x0 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(150, 200)) : 8'($urandom);
         y0 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(110, 130)) : 8'($urandom);
         run_copy($urandom_range(0, 1), f, x0, y0, int'($urandom_range(0, 1)));
      end
      run_copy(2, 4'($urandom), 8'd140, 8'd100, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Reader side of the animation pixel-memory interface.
- Sequences a sprite frame source: drives frame index `step` and pixel address `ram_addr_x`/`ram_addr_y`, and consumes `ram_data`.
- Copies one W x H frame into a framebuffer write port at a destination offset, with a colour-key transparency test and clipping.
- Sits between the animation ROM and the display framebuffer. Runs in the slow animation clock domain.

Parameters:
- `W`, 32, sprite width in pixels (2..256).
- `H`, 32, sprite height in pixels (2..256).
- `FB_W`, 160, framebuffer width; destination x >= `FB_W` is clipped.
- `FB_H`, 120, framebuffer height; destination y >= `FB_H` is clipped.
- `KEY`, 16'hF81F, transparent colour (RGB565).
- `KEY_EN`, 1, 1 = pixels equal to `KEY` are not written.

Ports:
- `clk_10` input 1: animation clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to copy a frame.
- `frame_sel` input 4: frame index, latched on accepted `start`.
- `dst_x` input 8: destination x origin, latched on accepted `start`.
- `dst_y` input 8: destination y origin, latched on accepted `start`.
- `step` output 4: frame index to the source memory.
- `ram_addr_x` output 8: source pixel column.
- `ram_addr_y` output 8: source pixel row.
- `ram_data` input 16: source pixel, combinational from the address.
- `wr_en` output 1: framebuffer write strobe.
- `wr_x` output 8: framebuffer column.
- `wr_y` output 8: framebuffer row.
- `wr_data` output 16: pixel to write.
- `busy` output 1: copy in progress.
- `done` output 1: one-cycle completion pulse.
- `wr_count` output 17: number of writes issued in the current/last copy.

Behaviour:
- Interface: reset `rst`, synchronous, active-high; clock `clk_10`. All state updates on posedge `clk_10`.
- Reset values: `step`, `ram_addr_x`, `ram_addr_y`, `wr_x`, `wr_y`, `wr_data`, `wr_count` = 0; `wr_en`, `busy`, `done` = 0; FSM = IDLE.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - `start`=1 latches `frame_sel` to `step`, and latches `dst_x`/`dst_y`.
  - Clears cx, cy and `wr_count`, then moves to RUN.
  - `busy`=1 from the next cycle.
- RUN: each cycle
  - `ram_addr_x`=cx, `ram_addr_y`=cy.
  - End of cycle: register `ram_data` plus dx = `dst_x`+cx and dy = `dst_y`+cy (9-bit, no wrap) into a write stage, with a valid flag.
  - cx increments. At cx=W-1, cx wraps to 0 and cy increments.
  - After issuing (W-1,H-1), move to FLUSH.
  - RUN lasts exactly W*H cycles.
- Write stage (registered, one cycle after the read):
  - `wr_en` = valid AND NOT(`KEY_EN` AND data==`KEY`) AND dx<`FB_W` AND dy<`FB_H`.
  - `wr_x`=dx[7:0], `wr_y`=dy[7:0], `wr_data`=data.
  - `wr_count` increments on each `wr_en`.
- FLUSH: one cycle in which the last pixel's write completes; valid then clears.
- DONE: `done`=1 for one cycle, `busy`=0 in the same cycle, then return to IDLE.
- Latency: `start` accepted at edge 0 → first address driven cycle 1 → first `wr_en` cycle 2 → `done` in cycle W*H+2.
- `step` and the origins hold their latched values until the next accepted `start`. `step` is a 4-bit wrap, values 0..15 are all legal.
- `start` while `busy` (RUN/FLUSH/DONE) is ignored; no restart, no queueing.
- `start` in the same cycle as `rst`: reset wins.
- `rst` mid-copy: next cycle `wr_en`=0 and `busy`=0, and `done` is not pulsed. Already-written pixels stay in the framebuffer.
- `ram_addr_x`/`ram_addr_y` hold their last value in IDLE; `wr_en`=0 outside the write stage.
- `wr_count` is stable from `done` until the next accepted `start`. Maximum is W*H = 65536, hence 17 bits.

Test Plan:
1. W=4, H=2, `dst`=(0,0), no key pixels; pulse `start` with `frame_sel`=3 → `step`=3; addresses (0,0),(1,0)..(3,0),(0,1)..(3,1) on cycles 1..8; 8 writes cycles 2..9 with `wr_data` matching source; `done` cycle 10; `wr_count`=8.
2. Same frame with source pixel (2,1)=16'hF81F → 7 writes, no write at (2,1), `wr_count`=7. Repeat with `KEY_EN`=0 → 8 writes.
3. Clipping: `dst_x`=158, `dst_y`=119, W=4, H=2, `FB_W`=160, `FB_H`=120 → only (158,119) and (159,119) written; `wr_count`=2; `done` still at cycle 10.
4. `start` pulsed again on cycle 5 of a copy → ignored; single `done`; `step` unchanged. `start` on the cycle after `done` → new copy begins normally.
5. `rst` asserted on cycle 4 of a copy → cycle 5: `wr_en`=0, `busy`=0, all outputs at reset values; no `done` ever seen; next `start` copies the full frame from (0,0).
6. Default W=H=32, `frame_sel`=15, `dst`=(200,0) → every write clipped; `wr_count`=0; `done` at cycle 1026.
